pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the five-stage datapath, replacing the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque payload (ALU result, register indices, store data, control flags) between stages using a valid/ready handshake. It adds:
- stall back-pressure with a registered upstream ready, via a two-entry skid buffer
- synchronous flush that inserts an all-zero bubble (NOP)
- a saturating stall counter for performance monitoring

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// Holds the stage state enum, default widths and the EX/MEM payload field layout.
package pipe_pkg;

  localparam int DEF_DATA_W = 79;
  localparam int DEF_CNT_W  = 16;

  // EX/MEM payload packing: ALU | rd | rt | dato_B | flags
  localparam int ALU_MSB    = 78;
  localparam int ALU_LSB    = 47;
  localparam int RD_MSB     = 46;
  localparam int RD_LSB     = 42;
  localparam int RT_MSB     = 41;
  localparam int RT_LSB     = 37;
  localparam int DATB_MSB   = 36;
  localparam int DATB_LSB   = 5;
  localparam int FLAG_MSB   = 4;
  localparam int FLAG_LSB   = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] dato_b;
    logic [4:0]  flags;
  } exmem_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [1:0] state_occ(state_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// Counts one per cycle while inc is high and sticks at the all-ones value.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with flush-to-bubble and a saturating stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic              in_xfer, out_xfer;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_ready_reg;

  assign in_ready = in_ready_reg;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  // main_reg is zeroed whenever the stage empties, so out_data is the bubble for free
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign occupancy = state_occ(state_reg);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
`ifdef PIPE_SKID_EN
    skid_next  = skid_reg;
`endif
    unique case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          state_next = ONE;
          main_next  = in_data;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_next = in_data;
`ifdef PIPE_SKID_EN
        end else if (in_xfer) begin
          state_next = FULL;
          skid_next  = in_data;
`endif
        end else if (out_xfer) begin
          state_next = EMPTY;
          main_next  = '0;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        if (out_xfer) begin
          state_next = ONE;
          main_next  = skid_reg;
          skid_next  = '0;
        end
      end
`endif
      default: begin
        state_next = EMPTY;
        main_next  = '0;
      end
    endcase

    // Squash wins over any same-cycle input; an output transfer already happened downstream
    if (flush) begin
      state_next = EMPTY;
      main_next  = '0;
`ifdef PIPE_SKID_EN
      skid_next  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
`ifdef PIPE_SKID_EN
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
`endif
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
`ifdef PIPE_SKID_EN
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != FULL);
`endif
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based reference model.
// Works with or without PIPE_SKID_EN; stage capacity is 2 or 1 accordingly.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DATA_W  = 79;
  localparam int CNT_W   = 16;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [DATA_W-1:0] exp_q[$];
  int                ref_stall = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage accepts when it has room; without skid it may also accept while emptying
  function automatic bit model_ready();
`ifdef PIPE_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                       input logic fl, input logic r);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  // Monitor: compare DUT against the model mid-cycle, then advance the model across the next edge
  bit                exp_valid, exp_rdy;
  logic [DATA_W-1:0] exp_data;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        exp_valid = exp_q.size() > 0;
        exp_data  = exp_valid ? exp_q[0] : '0;
        exp_rdy   = model_ready();
        check("in_ready",  DATA_W'(in_ready),  DATA_W'(exp_rdy));
        check("out_valid", DATA_W'(out_valid), DATA_W'(exp_valid));
        check("occupancy", DATA_W'(occupancy), DATA_W'(exp_q.size()));
        check("out_data",  out_data,           exp_data);
        check("stall_cnt", DATA_W'(stall_cnt), DATA_W'(ref_stall));
        if (rst) begin
          exp_q.delete();
          ref_stall = 0;
        end else begin
          if (exp_valid && !out_ready && ref_stall < SAT_MAX) ref_stall++;
          if (exp_valid && out_ready) begin
            void'(exp_q.pop_front());
            $display("out xfer data=%0h t=%0t", exp_data, $time);
          end
          if (flush) exp_q.delete();
          else if (in_valid && exp_rdy) exp_q.push_back(in_data);
        end
      end
    end
  end

  logic [95:0] rnd;
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = DATA_W'(32'h5a); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 8; i++) drive(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Stall: A and B enter, C waits upstream until the stage makes room
    drive(1'b1, DATA_W'(32'hA), 1'b0, 1'b0, 1'b0);
    drive(1'b1, DATA_W'(32'hB), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, DATA_W'(32'hC), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DATA_W'(32'hC), 1'b1, 1'b0, 1'b0);
      #1;
      if (in_ready) break;
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full with a competing input D that must vanish
    drive(1'b1, DATA_W'(32'hE1), 1'b0, 1'b0, 1'b0);
    drive(1'b1, DATA_W'(32'hE2), 1'b0, 1'b0, 1'b0);
    drive(1'b1, DATA_W'(32'hD),  1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Long stall to saturate the counter, then flush must leave it alone
    drive(1'b1, DATA_W'(32'h77), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    check("stall_sat", DATA_W'(stall_cnt), DATA_W'(SAT_MAX));
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    check("stall_after_flush", DATA_W'(stall_cnt), DATA_W'(SAT_MAX));
    drive(1'b1, DATA_W'(32'h99), 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      drive(($urandom_range(0, 9) < 7), rnd[DATA_W-1:0], ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 1));
    end
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
